fp_round_pipe: RTL and testbench



---
 rtl/fp_pkg.sv | 73 +++++++
 rtl/fp_round_pipe_if.sv | 25 ++
 rtl/fp_round_core.sv | 68 ++++++
 rtl/fp_round_pipe.sv | 121 ++++++++++++
 tb/tb_fp_round_pipe.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared FP types and rounding helpers used by the FP back-end units.
package fp_pkg;

    typedef enum logic [1:0] {
        FP16 = 2'd0,
        FP32 = 2'd1,
        FP64 = 2'd2
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } roundmode_e;

    localparam int MAX_FP_WIDTH = 64;

    // u_result is right-aligned in a container wide enough for the largest format
    typedef struct packed {
        logic [MAX_FP_WIDTH-1:0] u_result;
        logic [1:0]              rs;
        logic                    round_en;
        logic                    invalid;
        logic [1:0]              exp_cout;
    } uround_res_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    function automatic int fp_width(fp_format_e fmt);
        case (fmt)
            FP16:    return 16;
            FP64:    return 64;
            default: return 32;
        endcase
    endfunction

    function automatic int exp_width(fp_format_e fmt);
        case (fmt)
            FP16:    return 5;
            FP64:    return 11;
            default: return 8;
        endcase
    endfunction

    function automatic logic round_up(roundmode_e mode, logic sgn, logic l, logic g, logic s);
        case (mode)
            RNE:     return g & (s | l);
            RDN:     return sgn & (g | s);
            RUP:     return ~sgn & (g | s);
            RMM:     return g;
            default: return 1'b0;
        endcase
    endfunction

    // Returns 1 when an overflowed result saturates to infinity rather than max finite
    function automatic logic ovf_result(roundmode_e mode, logic sgn);
        case (mode)
            RNE, RMM: return 1'b1;
            RUP:      return ~sgn;
            RDN:      return sgn;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fp_round_pipe_if.sv
// Upstream/downstream valid-ready bus of the rounding pipeline.
interface fp_round_pipe_if #(parameter int FP_WIDTH = 32);
    import fp_pkg::*;

    logic                valid_i;
    logic                ready_o;
    uround_res_t         urnd_i;
    roundmode_e          rnd_i;
    logic                dz_i;
    logic                valid_o;
    logic                ready_i;
    logic [FP_WIDTH-1:0] result_o;
    logic [4:0]          fflags_o;

    modport master (
        output valid_i, urnd_i, rnd_i, dz_i, ready_i,
        input  ready_o, valid_o, result_o, fflags_o
    );

    modport slave (
        input  valid_i, urnd_i, rnd_i, dz_i, ready_i,
        output ready_o, valid_o, result_o, fflags_o
    );

endinterface

// File: rtl/fp_round_core.sv
// Combinational datapath: stage-1 rounding increment and stage-2 overflow/underflow fix.
module fp_round_core import fp_pkg::*; #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23
) (
    input  logic                                sign,
    input  logic [EXP_WIDTH+MANT_WIDTH-1:0]     exp_mant,
    input  logic [1:0]                          rs,
    input  logic                                round_en,
    input  roundmode_e                          mode,
    output logic [EXP_WIDTH+MANT_WIDTH:0]       sum,
    output logic                                inexact,

    input  logic                                s2_sign,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]       s2_sum,
    input  logic                                s2_round_en,
    input  logic                                s2_inexact,
    input  logic [1:0]                          s2_exp_cout,
    input  roundmode_e                          s2_mode,
    input  logic                                s2_nv,
    input  logic                                s2_dz,
    output logic [EXP_WIDTH+MANT_WIDTH:0]       result,
    output fflags_t                             flags
);

    localparam int W = EXP_WIDTH + MANT_WIDTH;

    logic                 up;
    logic [EXP_WIDTH-1:0] rexp;
    logic                 carry;
    logic                 uf_zero;
    logic                 ovf;

    assign up      = round_up(mode, sign, exp_mant[0], rs[1], rs[0]);
    assign sum     = {1'b0, exp_mant} + {{W{1'b0}}, round_en & up};
    assign inexact = round_en & (rs[1] | rs[0]);

    assign carry = s2_sum[W];
    assign rexp  = s2_sum[W-1:MANT_WIDTH];

    // A negative exponent makes the truncated sum meaningless, so underflow outranks overflow
    assign uf_zero = s2_round_en & s2_exp_cout[1];
    assign ovf     = s2_round_en & ~s2_exp_cout[1] & ((s2_exp_cout == 2'b01) | carry | (&rexp));

    always_comb begin
        flags    = '0;
        flags.nv = s2_nv;
        flags.dz = s2_dz;
        result   = {s2_sign, s2_sum[W-1:0]};
        if (uf_zero) begin
            result    = {s2_sign, {W{1'b0}}};
            result[0] = ((s2_mode == RUP) & ~s2_sign) | ((s2_mode == RDN) & s2_sign);
            flags.uf  = 1'b1;
            flags.nx  = 1'b1;
        end else if (ovf) begin
            if (ovf_result(s2_mode, s2_sign))
                result = {s2_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            else
                result = {s2_sign, {{(EXP_WIDTH-1){1'b1}}, 1'b0}, {MANT_WIDTH{1'b1}}};
            flags.of = 1'b1;
            flags.nx = 1'b1;
        end else if (s2_round_en) begin
            flags.uf = (rexp == '0) & s2_inexact;
            flags.nx = s2_inexact;
        end
    end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage elastic IEEE-754 rounding pipeline.
// Define FP_ROUND_ACC_FLAGS_EN to add the sticky fflags accumulator (clr_flags_i/fflags_acc_o).
module fp_round_pipe import fp_pkg::*; #(
    parameter fp_format_e FP_FORMAT = FP32
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic flush_i,
`ifdef FP_ROUND_ACC_FLAGS_EN
    input  logic       clr_flags_i,
    output logic [4:0] fflags_acc_o,
`endif
    fp_round_pipe_if.slave bus
);

    localparam int FP_WIDTH   = fp_width(FP_FORMAT);
    localparam int EXP_WIDTH  = exp_width(FP_FORMAT);
    localparam int MANT_WIDTH = FP_WIDTH - EXP_WIDTH - 1;

    logic                  s1_valid;
    logic [FP_WIDTH-1:0]   s1_sum;
    logic                  s1_sign;
    logic                  s1_round_en;
    logic                  s1_inexact;
    logic [1:0]            s1_exp_cout;
    roundmode_e            s1_mode;
    logic                  s1_nv;
    logic                  s1_dz;
    logic                  s2_valid;
    logic [FP_WIDTH-1:0]   s2_result;
    fflags_t               s2_flags;

    logic                  s1_advance;
    logic                  accept;
    logic [FP_WIDTH-1:0]   core_sum;
    logic                  core_inexact;
    logic [FP_WIDTH-1:0]   core_result;
    fflags_t               core_flags;

    if (FP_WIDTH < MAX_FP_WIDTH) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^bus.urnd_i.u_result[MAX_FP_WIDTH-1:FP_WIDTH];
    end

    assign s1_advance  = ~s2_valid | bus.ready_i;
    assign bus.ready_o = ~s1_valid | s1_advance;
    assign accept      = bus.valid_i & bus.ready_o;

    fp_round_core #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) core (
        .sign        (bus.urnd_i.u_result[FP_WIDTH-1]),
        .exp_mant    (bus.urnd_i.u_result[FP_WIDTH-2:0]),
        .rs          (bus.urnd_i.rs),
        .round_en    (bus.urnd_i.round_en),
        .mode        (bus.rnd_i),
        .sum         (core_sum),
        .inexact     (core_inexact),
        .s2_sign     (s1_sign),
        .s2_sum      (s1_sum),
        .s2_round_en (s1_round_en),
        .s2_inexact  (s1_inexact),
        .s2_exp_cout (s1_exp_cout),
        .s2_mode     (s1_mode),
        .s2_nv       (s1_nv),
        .s2_dz       (s1_dz),
        .result      (core_result),
        .flags       (core_flags)
    );

    // Flush kills both stages and wins over any accept in the same cycle
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_advance) s2_valid <= s1_valid;
            if (bus.ready_o) s1_valid <= bus.valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            s1_sum      <= core_sum;
            s1_sign     <= bus.urnd_i.u_result[FP_WIDTH-1];
            s1_round_en <= bus.urnd_i.round_en;
            s1_inexact  <= core_inexact;
            s1_exp_cout <= bus.urnd_i.exp_cout;
            s1_mode     <= bus.rnd_i;
            s1_nv       <= bus.urnd_i.invalid;
            s1_dz       <= bus.dz_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s1_valid & s1_advance) begin
            s2_result <= core_result;
            s2_flags  <= core_flags;
        end
    end

    assign bus.valid_o  = s2_valid;
    assign bus.result_o = s2_result;
    assign bus.fflags_o = s2_flags;

`ifdef FP_ROUND_ACC_FLAGS_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            fflags_acc_o <= '0;
        else if (clr_flags_i)
            fflags_acc_o <= '0;
        else if (s2_valid & bus.ready_i)
            fflags_acc_o <= fflags_acc_o | s2_flags;
    end
`endif

endmodule

// File: tb/tb_fp_round_pipe.sv
// Scoreboard testbench for fp_round_pipe (FP32); covers FP_ROUND_ACC_FLAGS_EN when defined.
module tb_fp_round_pipe;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    fp_round_pipe_if #(.FP_WIDTH(32)) bus ();

`ifdef FP_ROUND_ACC_FLAGS_EN
    logic       clr_flags = 1'b0;
    logic [4:0] fflags_acc;
`endif

    fp_round_pipe #(.FP_FORMAT(FP32)) dut (
        .clk_i        (clk),
        .reset_i      (reset_n),
        .flush_i      (flush),
`ifdef FP_ROUND_ACC_FLAGS_EN
        .clr_flags_i  (clr_flags),
        .fflags_acc_o (fflags_acc),
`endif
        .bus          (bus)
    );

    int          vector_count = 0;
    int          miss_count   = 0;
    logic [36:0] sb_q[$];
    logic [36:0] drv_exp = '0;
    logic [4:0]  acc_model = '0;
    bit          rand_done = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vector_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference rounding written on the magnitude, independent of the RTL's field split
    function automatic logic [36:0] model(roundmode_e mode, logic [31:0] u, logic [1:0] rs,
                                          logic en, logic inv, logic [1:0] ec, logic dz);
        logic        s, l, g, st, up, nx, uf, of;
        logic [31:0] mag;
        logic [31:0] r;
        s = u[31]; l = u[0]; g = rs[1]; st = rs[0];
        case (mode)
            RNE:     up = g & (st | l);
            RDN:     up = s & (g | st);
            RUP:     up = !s & (g | st);
            RMM:     up = g;
            default: up = 1'b0;
        endcase
        r = u; of = 0; uf = 0; nx = 0;
        if (en) begin
            nx  = g | st;
            mag = {1'b0, u[30:0]} + {31'd0, up};
            if (ec[1]) begin
                uf = 1; nx = 1;
                r = {s, 30'd0, ((mode == RUP) && !s) || ((mode == RDN) && s)};
            end else if (ec == 2'b01 || mag >= 32'h7F80_0000) begin
                of = 1; nx = 1;
                if (mode == RNE || mode == RMM || (mode == RUP && !s) || (mode == RDN && s))
                    r = {s, 31'h7F80_0000};
                else
                    r = {s, 31'h7F7F_FFFF};
            end else begin
                r  = {s, mag[30:0]};
                uf = (mag < 32'h0080_0000) && nx;
            end
        end
        return {inv, dz, of, uf, nx, r};
    endfunction

    // Sampled 1 unit before each rising edge: checks outputs, then tracks transfers
    always @(negedge clk) begin
        logic exp_ready;
        #4;
        if (!reset_n) begin
            sb_q.delete();
            acc_model = '0;
        end else begin
            exp_ready = (sb_q.size() < 2) || bus.ready_i;
            checkOutput("ready_o", 64'(bus.ready_o), 64'(exp_ready));
            if (bus.valid_o) begin
                if (sb_q.size() == 0)
                    checkOutput("spurious_valid_o", 64'(bus.valid_o), 64'd0);
                else begin
                    checkOutput("result_o", 64'(bus.result_o), 64'(sb_q[0][31:0]));
                    checkOutput("fflags_o", 64'(bus.fflags_o), 64'(sb_q[0][36:32]));
                end
            end
`ifdef FP_ROUND_ACC_FLAGS_EN
            checkOutput("fflags_acc_o", 64'(fflags_acc), 64'(acc_model));
            if (clr_flags)
                acc_model = '0;
            else if (bus.valid_o && bus.ready_i && sb_q.size() > 0)
                acc_model = acc_model | sb_q[0][36:32];
`endif
            if (bus.valid_o && bus.ready_i && sb_q.size() > 0) void'(sb_q.pop_front());
            if (flush)
                sb_q.delete();
            else if (bus.valid_i && bus.ready_o)
                sb_q.push_back(drv_exp);
        end
    end

    // Caller must be at a falling edge; leaves valid_i low at the falling edge after acceptance
    task automatic applyStimulus(input roundmode_e mode, input logic [31:0] u, input logic [1:0] rs,
                                 input logic en, input logic inv, input logic [1:0] ec,
                                 input logic dz, input logic [36:0] expv);
        bit accepted = 0;
        drv_exp                 = expv;
        bus.valid_i             = 1'b1;
        bus.rnd_i               = mode;
        bus.urnd_i              = '0;
        bus.urnd_i.u_result     = {32'd0, u};
        bus.urnd_i.rs           = rs;
        bus.urnd_i.round_en     = en;
        bus.urnd_i.invalid      = inv;
        bus.urnd_i.exp_cout     = ec;
        bus.dz_i                = dz;
        for (int i = 0; i < 40 && !accepted; i++) begin
            #4;
            if (bus.ready_o) accepted = 1;
            @(negedge clk);
        end
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
        bus.valid_i = 1'b0;
    endtask

    task automatic directed(input roundmode_e mode, input logic [31:0] u, input logic [1:0] rs,
                            input logic en, input logic inv, input logic [1:0] ec, input logic dz,
                            input logic [4:0] fl, input logic [31:0] r);
        applyStimulus(mode, u, rs, en, inv, ec, dz, {fl, r});
    endtask

    task automatic sendRandom();
        roundmode_e  mode;
        logic [31:0] u;
        logic [1:0]  rs, ec;
        logic        en, inv, dz;
        int          pick;
        mode = roundmode_e'($urandom_range(0, 4));
        u    = $urandom;
        rs   = 2'($urandom_range(0, 3));
        en   = ($urandom_range(0, 3) != 0);
        inv  = ($urandom_range(0, 7) == 0);
        dz   = ($urandom_range(0, 7) == 0);
        pick = $urandom_range(0, 7);
        ec   = (pick == 0) ? 2'b01 : (pick == 1) ? 2'b10 : 2'b00;
        applyStimulus(mode, u, rs, en, inv, ec, dz, model(mode, u, rs, en, inv, ec, dz));
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.urnd_i  = '0;
        bus.rnd_i   = RNE;
        bus.dz_i    = 1'b0;
        bus.ready_i = 1'b1;

        #12;
        checkOutput("reset_valid_o", 64'(bus.valid_o), 64'd0);
        checkOutput("reset_result_o", 64'(bus.result_o), 64'd0);
        checkOutput("reset_fflags_o", 64'(bus.fflags_o), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 checkOutput("reset_ready_o", 64'(bus.ready_o), 64'd1);
        @(negedge clk);

        // Two-cycle latency with ready_i high
        directed(RNE, 32'h3F80_0000, 2'b10, 1, 0, 2'b00, 0, 5'b00001, 32'h3F80_0000);
        #1 checkOutput("latency_early_valid_o", 64'(bus.valid_o), 64'd0);
        @(negedge clk);
        #1 checkOutput("latency_valid_o", 64'(bus.valid_o), 64'd1);
        @(negedge clk);

        directed(RNE, 32'h3F80_0000, 2'b11, 1, 0, 2'b00, 0, 5'b00001, 32'h3F80_0001);
        directed(RUP, 32'h3F80_0000, 2'b01, 1, 0, 2'b00, 0, 5'b00001, 32'h3F80_0001);
        directed(RDN, 32'h3F80_0000, 2'b01, 1, 0, 2'b00, 0, 5'b00001, 32'h3F80_0000);
        directed(RNE, 32'h7F7F_FFFF, 2'b11, 1, 0, 2'b01, 0, 5'b00101, 32'h7F80_0000);
        directed(RTZ, 32'h7F7F_FFFF, 2'b11, 1, 0, 2'b01, 0, 5'b00101, 32'h7F7F_FFFF);
        directed(RNE, 32'h7FC0_0000, 2'b00, 0, 1, 2'b00, 0, 5'b10000, 32'h7FC0_0000);
        directed(RNE, 32'h7F80_0000, 2'b00, 0, 0, 2'b00, 1, 5'b01000, 32'h7F80_0000);
        directed(RNE, 32'h3F80_0001, 2'b10, 1, 0, 2'b00, 0, 5'b00001, 32'h3F80_0002);
        directed(RMM, 32'h3F80_0000, 2'b10, 1, 0, 2'b00, 0, 5'b00001, 32'h3F80_0001);
        directed(RDN, 32'hBF80_0000, 2'b01, 1, 0, 2'b00, 0, 5'b00001, 32'hBF80_0001);
        directed(RNE, 32'h7F7F_FFFF, 2'b10, 1, 0, 2'b00, 0, 5'b00101, 32'h7F80_0000);
        directed(RUP, 32'hFF7F_FFFF, 2'b11, 1, 0, 2'b01, 0, 5'b00101, 32'hFF7F_FFFF);
        directed(RUP, 32'h0000_0000, 2'b01, 1, 0, 2'b10, 0, 5'b00011, 32'h0000_0001);
        directed(RNE, 32'h8000_0000, 2'b11, 1, 0, 2'b11, 0, 5'b00011, 32'h8000_0000);
        directed(RDN, 32'h8000_0001, 2'b00, 1, 0, 2'b10, 0, 5'b00011, 32'h8000_0001);
        directed(RNE, 32'h0000_0001, 2'b10, 1, 0, 2'b00, 0, 5'b00011, 32'h0000_0002);
        directed(RNE, 32'h007F_FFFF, 2'b11, 1, 0, 2'b00, 0, 5'b00001, 32'h0080_0000);
        directed(RTZ, 32'h3F80_0000, 2'b00, 1, 0, 2'b00, 0, 5'b00000, 32'h3F80_0000);
        directed(RNE, 32'h1234_5678, 2'b11, 0, 0, 2'b01, 0, 5'b00000, 32'h1234_5678);

        // Backpressure: four back-to-back entries against a three-cycle stall
        fork
            begin
                bus.ready_i = 1'b0;
                repeat (3) @(negedge clk);
                bus.ready_i = 1'b1;
            end
            begin
                for (int k = 0; k < 4; k++)
                    directed(RUP, 32'h3F80_0000 + 32'(k), 2'b01, 1, 0, 2'b00, 0,
                             5'b00001, 32'h3F80_0001 + 32'(k));
            end
        join
        repeat (4) @(negedge clk);

        // Flush with two entries in flight and a new entry offered the same cycle
        bus.ready_i = 1'b0;
        directed(RNE, 32'h4000_0000, 2'b00, 1, 0, 2'b00, 0, 5'b00000, 32'h4000_0000);
        directed(RNE, 32'h4040_0000, 2'b00, 1, 0, 2'b00, 0, 5'b00000, 32'h4040_0000);
        bus.ready_i = 1'b1;
        flush = 1'b1;
        bus.valid_i = 1'b1;
        bus.urnd_i.u_result = 64'h4080_0000;
        @(negedge clk);
        flush = 1'b0;
        bus.valid_i = 1'b0;
        #1 checkOutput("flush_valid_o", 64'(bus.valid_o), 64'd0);
        repeat (4) @(negedge clk);

        // Randomised traffic with random backpressure
        fork
            begin
                for (int k = 0; k < 60; k++) sendRandom();
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    bus.ready_i = ($urandom_range(0, 3) != 0);
`ifdef FP_ROUND_ACC_FLAGS_EN
                    clr_flags = ($urandom_range(0, 7) == 0);
`endif
                    @(negedge clk);
                end
            end
        join
        bus.ready_i = 1'b1;
`ifdef FP_ROUND_ACC_FLAGS_EN
        clr_flags = 1'b0;
`endif
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        checkOutput("drain_empty", 64'(sb_q.size()), 64'd0);

        // Asynchronous reset with entries in flight
        bus.ready_i = 1'b0;
        directed(RUP, 32'h4100_0000, 2'b01, 1, 0, 2'b00, 0, 5'b00001, 32'h4100_0001);
        directed(RUP, 32'h4110_0000, 2'b01, 1, 0, 2'b00, 0, 5'b00001, 32'h4110_0001);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midreset_valid_o", 64'(bus.valid_o), 64'd0);
        checkOutput("midreset_result_o", 64'(bus.result_o), 64'd0);
        checkOutput("midreset_fflags_o", 64'(bus.fflags_o), 64'd0);
`ifdef FP_ROUND_ACC_FLAGS_EN
        checkOutput("midreset_fflags_acc_o", 64'(fflags_acc), 64'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        bus.ready_i = 1'b1;
        repeat (4) @(negedge clk);
        directed(RNE, 32'h3F80_0000, 2'b11, 1, 0, 2'b00, 0, 5'b00001, 32'h3F80_0001);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        checkOutput("final_drain_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
